// File: rtl/iob_ram_sp_fifo_ctrl_if.sv
// Purpose: bundles the push/pop streams, fill level and single-port RAM port of the FIFO controller.
// Latency: none, wires only.
// Backpressure: w_ready/r_ready handshakes travel through this bundle unchanged.
interface iob_ram_sp_fifo_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 14
);
    logic              w_valid;
    logic              w_ready;
    logic [DATA_W-1:0] w_data;
    logic              r_valid;
    logic              r_ready;
    logic [DATA_W-1:0] r_data;
    logic [ADDR_W+1:0] level;
    logic              ext_mem_en;
    logic              ext_mem_we;
    logic [ADDR_W-1:0] ext_mem_addr;
    logic [DATA_W-1:0] ext_mem_din;
    logic [DATA_W-1:0] ext_mem_dout;

    // Controller side
    modport slave (
        input  w_valid, w_data, r_ready, ext_mem_dout,
        output w_ready, r_valid, r_data, level,
               ext_mem_en, ext_mem_we, ext_mem_addr, ext_mem_din
    );

    // User / RAM side
    modport master (
        output w_valid, w_data, r_ready, ext_mem_dout,
        input  w_ready, r_valid, r_data, level,
               ext_mem_en, ext_mem_we, ext_mem_addr, ext_mem_din
    );
endinterface

// File: rtl/iob_ram_sp_fifo_ctrl.sv
// Purpose: turns a 1-cycle-latency single-port RAM into a 2**ADDR_W(+2) deep valid/ready FIFO.
// Latency: no bypass; a push into an empty FIFO shows r_valid three cycles later.
// Backpressure: w_ready drops when RAM is full or the port is taken by a prefetch; r_data holds while stalled.
module iob_ram_sp_fifo_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 14
) (
    input  logic                   clk,
    input  logic                   rst,
    iob_ram_sp_fifo_ctrl_if.slave  bus
);
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   ram_cnt_q, ram_cnt_d;
    logic              inflight_q, inflight_d;
    logic [1:0]        buf_cnt_q, buf_cnt_d;
    logic [DATA_W-1:0] buf0_q, buf0_d;
    logic [DATA_W-1:0] buf1_q, buf1_d;
    logic [ADDR_W+1:0] level_q, level_d;

    logic       pop;
    logic [2:0] occ;
    logic       ram_full;
    logic       rd_issue;
    logic       w_ready_int;
    logic       wr_fire;

    // Port arbitration: prefetch only when the output side needs a word or nothing else wants the port
    always_comb begin
        pop         = (buf_cnt_q != 2'd0) & bus.r_ready;
        occ         = {1'b0, buf_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
        ram_full    = (ram_cnt_q == DEPTH);
        rd_issue    = !rst & (ram_cnt_q != '0) & (occ < 3'd2)
                      & ((occ == 3'd0) | !bus.w_valid | ram_full);
        w_ready_int = !rst & !rd_issue & !ram_full;
        wr_fire     = bus.w_valid & w_ready_int;
    end

    // RAM port and stream outputs driven from current state and inputs
    always_comb begin
        bus.w_ready      = w_ready_int;
        bus.r_valid      = (buf_cnt_q != 2'd0);
        bus.r_data       = buf0_q;
        bus.level        = level_q;
        bus.ext_mem_en   = rd_issue | wr_fire;
        bus.ext_mem_we   = wr_fire;
        bus.ext_mem_addr = wr_fire ? wr_ptr_q : rd_ptr_q;
        bus.ext_mem_din  = bus.w_data;
    end

    // Next state: pointers/count follow the port op; buffer shifts on pop then takes the returning word
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        ram_cnt_d  = ram_cnt_q;
        inflight_d = rd_issue;
        buf0_d     = buf0_q;
        buf1_d     = buf1_q;
        buf_cnt_d  = buf_cnt_q;

        if (wr_fire) begin
            wr_ptr_d  = wr_ptr_q + 1'b1;
            ram_cnt_d = ram_cnt_q + 1'b1;
        end else if (rd_issue) begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            ram_cnt_d = ram_cnt_q - 1'b1;
        end

        // Only shift when a second entry exists so r_data keeps its last value once empty
        if (pop) begin
            if (buf_cnt_q == 2'd2) begin
                buf0_d = buf1_q;
            end
            buf_cnt_d = buf_cnt_q - 2'd1;
        end

        // Word read last cycle is on ext_mem_dout now
        if (inflight_q) begin
            if (buf_cnt_d == 2'd0) begin
                buf0_d = bus.ext_mem_dout;
            end else begin
                buf1_d = bus.ext_mem_dout;
            end
            buf_cnt_d = buf_cnt_d + 2'd1;
        end

        level_d = (ADDR_W+2)'(ram_cnt_d) + (ADDR_W+2)'(inflight_d) + (ADDR_W+2)'(buf_cnt_d);
    end

    // State registers, cleared immediately by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ram_cnt_q  <= '0;
            inflight_q <= 1'b0;
            buf_cnt_q  <= 2'd0;
            buf0_q     <= '0;
            buf1_q     <= '0;
            level_q    <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ram_cnt_q  <= ram_cnt_d;
            inflight_q <= inflight_d;
            buf_cnt_q  <= buf_cnt_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            level_q    <= level_d;
        end
    end
endmodule

// File: tb/tb_iob_ram_sp_fifo_ctrl.sv
// Bench for iob_ram_sp_fifo_ctrl with ADDR_W=3 and a behavioural single-port RAM.
// Inputs change 1 time unit after posedge; outputs and handshakes are sampled on negedge.
// A queue scoreboard records every accepted push and compares it with every pop.
module tb_iob_ram_sp_fifo_ctrl;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    iob_ram_sp_fifo_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    iob_ram_sp_fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Single-port RAM: 1-cycle read latency, dout changes only on reads
    logic [DATA_W-1:0] ram_mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] ram_dout = '0;
    always @(posedge clk) begin
        if (bus.ext_mem_en) begin
            if (bus.ext_mem_we) ram_mem[bus.ext_mem_addr] <= bus.ext_mem_din;
            else                ram_dout <= ram_mem[bus.ext_mem_addr];
        end
    end
    assign bus.ext_mem_dout = ram_dout;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    logic [DATA_W-1:0] sb [$];
    logic [ADDR_W-1:0] wr_exp = '0;
    logic [ADDR_W-1:0] rd_exp = '0;
    logic              stall_prev = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;
    int                rx_cnt = 0;
    int                lvl_max = 0;
    int                cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: addresses must walk and wrap in order, stalled data must hold, pops follow pushes
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            wr_exp     = '0;
            rd_exp     = '0;
            stall_prev = 1'b0;
        end else begin
            if (bus.ext_mem_en) begin
                if (bus.ext_mem_we) begin
                    check("wr_addr", 32'(bus.ext_mem_addr), 32'(wr_exp));
                    wr_exp = wr_exp + 1'b1;
                end else begin
                    check("rd_addr", 32'(bus.ext_mem_addr), 32'(rd_exp));
                    rd_exp = rd_exp + 1'b1;
                end
            end
            if (stall_prev) begin
                check("stall_r_valid", 32'(bus.r_valid), 32'd1);
                check("stall_r_data", 32'(bus.r_data), 32'(prev_data));
            end
            if (bus.w_valid && bus.w_ready) sb.push_back(bus.w_data);
            if (bus.r_valid && bus.r_ready) begin
                if (sb.size() == 0) check("sb_underflow", 32'd1, 32'd0);
                else                check("r_data", 32'(bus.r_data), 32'(sb.pop_front()));
                rx_cnt++;
            end
            stall_prev = bus.r_valid && !bus.r_ready;
            prev_data  = bus.r_data;
            if (int'(bus.level) > lvl_max) lvl_max = int'(bus.level);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [DATA_W-1:0] d, input int budget, output bit acc);
        acc = 1'b0;
        bus.w_valid = 1'b1;
        bus.w_data  = d;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (bus.w_ready) begin
                acc = 1'b1;
                break;
            end
        end
        next_cycle();
        bus.w_valid = 1'b0;
    endtask

    task automatic wait_r_valid(input string tag, input int budget);
        bit seen = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (bus.r_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check(tag, 32'(seen), 32'd1);
        next_cycle();
    endtask

    task automatic pop_one();
        bus.r_ready = 1'b1;
        next_cycle();
        bus.r_ready = 1'b0;
    endtask

    task automatic drain(input string tag, input int budget);
        bit done = 1'b0;
        bus.w_valid = 1'b0;
        bus.r_ready = 1'b1;
        for (int n = 0; n < budget; n++) begin
            next_cycle();
            if (sb.size() == 0 && bus.level == '0 && !bus.r_valid) begin
                done = 1'b1;
                break;
            end
        end
        check(tag, 32'(done), 32'd1);
        bus.r_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int accepted;
        int sent;
        int start;
        int base;
        bit done;

        bus.w_valid = 1'b1;
        bus.w_data  = 8'h5A;
        bus.r_ready = 1'b0;

        // Reset state, with a push pending to show the port stays quiet
        repeat (2) @(negedge clk);
        check("rst_r_valid", 32'(bus.r_valid), 32'd0);
        check("rst_r_data", 32'(bus.r_data), 32'd0);
        check("rst_level", 32'(bus.level), 32'd0);
        check("rst_w_ready", 32'(bus.w_ready), 32'd0);
        check("rst_mem_en", 32'(bus.ext_mem_en), 32'd0);
        bus.w_valid = 1'b0;
        next_cycle();
        rst = 1'b0;

        // 1. Latency of a single push into an empty FIFO
        bus.w_valid = 1'b1;
        bus.w_data  = 8'h11;
        @(negedge clk);
        check("lat_w_ready_c0", 32'(bus.w_ready), 32'd1);
        next_cycle();
        bus.w_valid = 1'b0;
        @(negedge clk);
        check("lat_level_c1", 32'(bus.level), 32'd1);
        check("lat_r_valid_c1", 32'(bus.r_valid), 32'd0);
        @(negedge clk);
        check("lat_r_valid_c2", 32'(bus.r_valid), 32'd0);
        @(negedge clk);
        check("lat_r_valid_c3", 32'(bus.r_valid), 32'd1);
        check("lat_r_data_c3", 32'(bus.r_data), 32'h11);
        check("lat_level_c3", 32'(bus.level), 32'd1);
        next_cycle();
        drain("lat_drain", 20);

        // 2. Fill to DEPTH+2 with no reads, then drain in order
        accepted = 0;
        for (int i = 0; i < 12; i++) begin
            push_word(8'(i), 30, acc);
            if (acc) accepted++;
        end
        bus.w_valid = 1'b1;
        bus.w_data  = 8'h0C;
        @(negedge clk);
        check("fill_accepted", 32'(accepted), 32'd10);
        check("fill_w_ready", 32'(bus.w_ready), 32'd0);
        check("fill_level", 32'(bus.level), 32'd10);
        check("fill_sb_size", 32'(sb.size()), 32'd10);
        next_cycle();
        drain("fill_drain", 60);

        // 3. Continuous streaming with reads always ready
        lvl_max = 0;
        base    = rx_cnt;
        start   = cyc;
        sent    = 0;
        bus.r_ready = 1'b1;
        bus.w_valid = 1'b1;
        bus.w_data  = 8'd0;
        done = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (bus.w_valid && bus.w_ready) sent++;
            if (rx_cnt - base >= 100) begin
                done = 1'b1;
                break;
            end
            next_cycle();
            bus.w_valid = (sent < 100);
            bus.w_data  = 8'(sent);
        end
        check("stream_done", 32'(done), 32'd1);
        check("stream_rate_ok", 32'((cyc - start) <= 210), 32'd1);
        check("stream_level_max_ok", 32'(lvl_max <= 3), 32'd1);
        next_cycle();
        drain("stream_drain", 20);

        // 4. Random push/pop pressure
        sent = 0;
        for (int n = 0; n < 20000 && sent < 500; n++) begin
            bus.w_valid = 1'($urandom_range(0, 1));
            bus.w_data  = 8'($urandom);
            bus.r_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (bus.w_valid && bus.w_ready) sent++;
            next_cycle();
        end
        check("rand_sent", 32'(sent), 32'd500);
        drain("rand_drain", 100);

        // 5. One word at a time through an empty FIFO, wrapping both pointers
        for (int i = 0; i < 20; i++) begin
            push_word(8'(i * 7 + 3), 20, acc);
            check("wrap_accept", 32'(acc), 32'd1);
            wait_r_valid("wrap_r_valid", 20);
            check("wrap_head", 32'(bus.r_data), 32'((i * 7 + 3) & 8'hFF));
            pop_one();
        end
        drain("wrap_drain", 20);

        // 6. Reset while holding five words
        for (int i = 0; i < 5; i++) begin
            push_word(8'(8'hC0 + i), 20, acc);
        end
        repeat (4) next_cycle();
        check("rmid_level_before", 32'(bus.level), 32'd5);
        bus.w_valid = 1'b1;
        bus.w_data  = 8'h55;
        rst = 1'b1;
        #1;
        check("rmid_level", 32'(bus.level), 32'd0);
        check("rmid_r_valid", 32'(bus.r_valid), 32'd0);
        check("rmid_mem_en", 32'(bus.ext_mem_en), 32'd0);
        check("rmid_w_ready", 32'(bus.w_ready), 32'd0);
        bus.w_valid = 1'b0;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("rmid_level_after", 32'(bus.level), 32'd0);
        next_cycle();
        push_word(8'hAA, 20, acc);
        check("rmid_accept", 32'(acc), 32'd1);
        wait_r_valid("rmid_r_valid_aa", 20);
        check("rmid_first_word", 32'(bus.r_data), 32'hAA);
        pop_one();
        drain("rmid_drain", 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
